hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage RV64IM core. It sequences the IF/ID and ID/EX registers (decode1's `decode_en` and `inCtrlMux`) and the EX/MEM hold. Four conditions drive it: load-use hazards, taken branches, multi-cycle mul/div/rem operations, and outstanding data-memory transactions. It also keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller: load-use bubbles, branch flushes,
// multi-cycle mul/div holds, data-memory waits and a saturating stall counter.
module hazard_ctrl #(
    parameter int unsigned MULDIV_LAT = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        idexMemRead,
    input  logic [4:0]  idexDestReg,
    input  logic [4:0]  ifidRs,
    input  logic [4:0]  ifidRt,
    input  logic        ifidUsesRt,
    input  logic        exValid,
    input  logic [5:0]  exAluControl,
    input  logic        exBranchTaken,
    input  logic        memReq,
    input  logic        memDone,
    output logic        fetchEn,
    output logic        decodeEn,
    output logic        ctrlMux,
    output logic        flush,
    output logic        exHold,
    output logic [1:0]  state,
    output logic [31:0] stallCycles
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned STAT_W = 32;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MULDIV  = 2'd1;
    localparam logic [1:0] ST_MEMWAIT = 2'd2;

    localparam logic [5:0]       ALU_MD_LO = 6'd31;
    localparam logic [5:0]       ALU_MD_HI = 6'd43;
    localparam logic [CNT_W-1:0] MD_RELOAD = CNT_W'(MULDIV_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              md_done_q, md_done_d;
    logic [STAT_W-1:0] stall_q, stall_d;
    logic              md_start_c;
    logic              load_use_c;

    assign md_start_c = exValid && (exAluControl >= ALU_MD_LO) &&
                        (exAluControl <= ALU_MD_HI) && !md_done_q;

    assign load_use_c = idexMemRead && (idexDestReg != 5'd0) &&
                        ((idexDestReg == ifidRs) ||
                         (ifidUsesRt && (idexDestReg == ifidRt)));

    // Next-state and combinational outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        md_done_d = md_done_q;
        fetchEn   = 1'b1;
        decodeEn  = 1'b1;
        ctrlMux   = 1'b0;
        flush     = 1'b0;
        exHold    = 1'b0;

        if (!reset_n) begin
            fetchEn  = 1'b0;
            decodeEn = 1'b0;
            ctrlMux  = 1'b1;
            flush    = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    md_done_d = 1'b0;
                    if (memReq && !memDone) begin
                        fetchEn  = 1'b0;
                        decodeEn = 1'b0;
                        exHold   = 1'b1;
                        state_d  = ST_MEMWAIT;
                    end else if (exBranchTaken) begin
                        flush   = 1'b1;
                        ctrlMux = 1'b1;
                    end else if (md_start_c) begin
                        fetchEn  = 1'b0;
                        decodeEn = 1'b0;
                        exHold   = 1'b1;
                        if (MULDIV_LAT > 1) begin
                            cnt_d   = MD_RELOAD;
                            state_d = ST_MULDIV;
                        end else begin
                            md_done_d = 1'b1;
                        end
                    end else if (load_use_c) begin
                        fetchEn  = 1'b0;
                        decodeEn = 1'b0;
                        ctrlMux  = 1'b1;
                    end
                end
                ST_MULDIV: begin
                    fetchEn  = 1'b0;
                    decodeEn = 1'b0;
                    exHold   = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d   = ST_RUN;
                        md_done_d = 1'b1;
                    end
                end
                ST_MEMWAIT: begin
                    fetchEn  = 1'b0;
                    decodeEn = 1'b0;
                    exHold   = 1'b1;
                    if (memDone) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Saturating count of cycles with fetch stalled.
    always_comb begin
        stall_d = stall_q;
        if (!fetchEn && (stall_q != {STAT_W{1'b1}})) begin
            stall_d = stall_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            md_done_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            md_done_q <= md_done_d;
            stall_q   <= stall_d;
        end
    end

    assign state       = state_q;
    assign stallCycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic,
// each cycle's expected outputs come from a hold-budget reference model.
module tb_hazard_ctrl;

    localparam int unsigned LAT = 8;

    typedef struct packed {
        logic        fe;
        logic        de;
        logic        cm;
        logic        fl;
        logic        eh;
        logic [1:0]  st;
        logic [31:0] sc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        idexMemRead = 1'b0;
    logic [4:0]  idexDestReg = '0;
    logic [4:0]  ifidRs = '0;
    logic [4:0]  ifidRt = '0;
    logic        ifidUsesRt = 1'b0;
    logic        exValid = 1'b0;
    logic [5:0]  exAluControl = '0;
    logic        exBranchTaken = 1'b0;
    logic        memReq = 1'b0;
    logic        memDone = 1'b0;
    logic        fetchEn, decodeEn, ctrlMux, flush, exHold;
    logic [1:0]  state;
    logic [31:0] stallCycles;

    hazard_ctrl #(.MULDIV_LAT(LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .idexMemRead(idexMemRead), .idexDestReg(idexDestReg),
        .ifidRs(ifidRs), .ifidRt(ifidRt), .ifidUsesRt(ifidUsesRt),
        .exValid(exValid), .exAluControl(exAluControl),
        .exBranchTaken(exBranchTaken), .memReq(memReq), .memDone(memDone),
        .fetchEn(fetchEn), .decodeEn(decodeEn), .ctrlMux(ctrlMux),
        .flush(flush), .exHold(exHold), .state(state),
        .stallCycles(stallCycles)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: which wait the core is in and how many hold cycles remain.
    int          m_mode = 0;       // 0 running, 1 mul/div wait, 2 memory wait
    int          m_left = 0;       // mul/div hold cycles still owed after this one
    bit          m_release = 1'b0; // mul/div instruction is leaving EX this cycle
    logic [31:0] m_stall = '0;

    task automatic step(input bit rst_n, input bit mrd, input int dst, input int rs,
                        input int rt, input bit urt, input bit exv, input int alu,
                        input bit br, input bit mreq, input bit mdone);
        exp_t e;
        bit   md, lu;
        int   n_mode;
        int   n_left;
        bit   n_rel;
        @(posedge clk);
        #1;
        reset_n = rst_n; idexMemRead = mrd; idexDestReg = 5'(dst);
        ifidRs = 5'(rs); ifidRt = 5'(rt); ifidUsesRt = urt;
        exValid = exv; exAluControl = 6'(alu); exBranchTaken = br;
        memReq = mreq; memDone = mdone;

        e.st = 2'(m_mode);
        e.sc = m_stall;
        {e.fe, e.de, e.cm, e.fl, e.eh} = 5'b11000;
        n_mode = m_mode; n_left = m_left; n_rel = 1'b0;
        md = exv && alu >= 31 && alu <= 43 && !m_release;
        lu = mrd && dst != 0 && (dst == rs || (urt && dst == rt));

        if (!rst_n) begin
            {e.fe, e.de, e.cm, e.fl, e.eh} = 5'b00110;
            n_mode = 0; n_left = 0;
        end else if (m_mode == 1) begin
            {e.fe, e.de, e.eh} = 3'b001;
            n_left = m_left - 1;
            if (n_left == 0) begin
                n_mode = 0; n_rel = 1'b1;
            end
        end else if (m_mode == 2) begin
            {e.fe, e.de, e.eh} = 3'b001;
            if (mdone) n_mode = 0;
        end else if (mreq && !mdone) begin
            {e.fe, e.de, e.eh} = 3'b001;
            n_mode = 2;
        end else if (br) begin
            {e.cm, e.fl} = 2'b11;
        end else if (md) begin
            {e.fe, e.de, e.eh} = 3'b001;
            if (LAT > 1) begin
                n_mode = 1; n_left = LAT - 1;
            end else begin
                n_rel = 1'b1;
            end
        end else if (lu) begin
            {e.fe, e.de, e.cm} = 3'b001;
        end

        // Memory-wait cycles leave the mul/div release marker untouched.
        if (rst_n && m_mode == 2) n_rel = m_release;

        if (!rst_n) m_stall = '0;
        else if (!e.fe && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
        m_mode = n_mode; m_left = n_left; m_release = n_rel;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare the DUT outputs of each cycle against the queued expectation.
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {fetchEn, decodeEn, ctrlMux, flush, exHold, state, stallCycles};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL cycle_outputs t=%0t got fe=%b de=%b cm=%b fl=%b eh=%b st=%0d sc=%0d expected fe=%b de=%b cm=%b fl=%b eh=%b st=%0d sc=%0d",
                             $time, a.fe, a.de, a.cm, a.fl, a.eh, a.st, a.sc,
                             e.fe, e.de, e.cm, e.fl, e.eh, e.st, e.sc);
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Load-use, then a zero destination that must not stall.
        step(1, 1, 5, 5, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 7, 1, 7, 1, 0, 0, 0, 0, 0);
        step(1, 1, 7, 1, 7, 0, 0, 0, 0, 0, 0);
        // Branch outranks load-use.
        step(1, 1, 5, 5, 0, 0, 0, 0, 1, 0, 0);
        idle(1);
        // Mul/div held steady in EX: 8 holds then release.
        for (int i = 0; i < LAT + 1; i++) step(1, 0, 0, 0, 0, 0, 1, 31, 0, 0, 0);
        idle(2);
        // Memory wait of 3 cycles, then same-cycle completion.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1);
        // Memory first, then the frozen mul/div starts.
        step(1, 0, 0, 0, 0, 0, 1, 35, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 35, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 35, 0, 1, 1);
        for (int i = 0; i < LAT + 1; i++) step(1, 0, 0, 0, 0, 0, 1, 35, 0, 0, 0);
        idle(1);
        // Reset while a mul/div hold has 4 cycles left.
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 1, 40, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 40, 0, 0, 0);
        idle(2);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) >= 2,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 2) == 0) ? $urandom_range(31, 43) : $urandom_range(0, 63),
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 2) == 0);
        end
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
